byte_lane_unpacker: RTL and testbench
=====================================

// Module: byte_lane_unpacker
// PURPOSE
//  Reader side of the byte-enabled 16-bit word path: takes a word + byteena, emits only the enabled lanes.
//  Output is a serial byte stream, one lane per beat, with a valid/ready handshake on each side.
//  Disabled lanes are skipped, never zero-filled. Sits between the byte-masked word source and the 8-bit consumers.
// PARAMETERS
//  LANES   2   number of byte lanes (byteena width); W = LANES*LANE_W
//  LANE_W  8   bits per lane
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          word offered
//  in_ready   out  1          word accepted when in_valid && in_ready
//  byteena    in   LANES      lane enables; bit i qualifies d[i*LANE_W +: LANE_W]
//  d          in   W          word data; disabled lanes ignored
//  out_valid  out  1          byte beat valid
//  out_ready  in   1          beat consumed when out_valid && out_ready
//  q          out  LANE_W     lane data
//  q_lane     out  clog2(LANES) (min 1)  source lane index of q
//  q_last     out  1          high on final enabled lane of the word
// BEHAVIOUR
//  - Reset (clk edge with reset=1): state IDLE; out_valid=0, q=0, q_lane=0, q_last=0; held word/mask cleared.
//    in_ready=0 while reset is high, 1 in the first cycle after reset.
//  - FSM IDLE / SEND. Registers: word_r[W], mask_r[LANES].
//  - IDLE: in_ready=1. Accept with byteena!=0 -> load word_r and mask_r from the lowest enabled lane.
//    Present that lane on q/q_lane next cycle with out_valid=1; go to SEND.
//  - Accept with byteena==0: word consumed in one cycle, no beat produced, stay IDLE.
//  - SEND: out_valid=1; q/q_lane/q_last held stable until the handshake.
//    Handshake, not last: clear lane bit in mask_r; present the next enabled lane next cycle.
//    Handshake, last: in_ready=1 in the same cycle (comb. on out_ready && q_last); a new word can be accepted with no bubble.
//    If a nonzero word is accepted: load and present its first lane next cycle, stay SEND. Otherwise go to IDLE, out_valid=0.
//  - in_ready=0 in SEND except the last-handshake case above; upstream must hold d/byteena while in_valid && !in_ready.
//  - Throughput: a word with k enabled lanes uses exactly k out beats.
//  - Latency: accept to first out_valid = 1 cycle.
//  - q_last is 1 when at most one bit of mask_r remains set.
//  - Reset mid-word drops the remaining lanes; no beat is emitted for them.
//  - out_ready may be held low indefinitely; no state change while stalled.
// CONFIGURATION
//  UNPACK_MSB_FIRST_EN defined: lanes are emitted highest-index first (lane LANES-1 .. 0), skipping disabled lanes.
//  Undefined (default): lanes are emitted lowest-index first (0 .. LANES-1).
//  Only the lane order changes; q_lane always reports the true source index, and handshakes and latency are identical.
// STRUCTURE
//  Package byte_lane_pkg:
//    LANES, LANE_W defaults; lane_idx_t = logic [clog2(LANES)-1:0]; state_t enum {IDLE, SEND}
//    function first_lane(mask, msb_first) -> lane_idx_t; function onehot_cnt_le1(mask) for q_last
//  Sub-module lane_prio_enc (param LANES, MSB_FIRST):
//    input mask; outputs idx and any; pure combinational priority encoder
//    one instance serves both the incoming byteena and mask_r (muxed by state)
// TESTING
//  1. byteena=2'b11, d=16'hA55A, out_ready=1
//     -> beats q=5A lane0 last0, then q=A5 lane1 last1; in_ready=1 on the 2nd beat.
//  2. byteena=2'b10, d=16'h1234 -> single beat q=12 lane1 last1.
//     byteena=2'b01, d=16'h1234 -> single beat q=34 lane0 last1.
//  3. byteena=2'b00 with in_valid for 3 words -> in_ready stays 1, 3 accepts, out_valid never asserts.
//  4. Back-to-back: words 16'h1111/11, 16'h2222/11, out_ready=1 -> 4 consecutive beats 11,11,22,22, no idle cycle.
//  5. Backpressure: out_ready=0 for 5 cycles on beat 1 of 16'hBEEF/11
//     -> q=EF held stable and in_ready=0 throughout; release -> EF then BE.
//  6. reset=1 after beat 1 of 16'hCAFE/11 -> next cycle out_valid=0, q=0.
//     Fresh word 16'h0077/01 -> single beat q=77 lane0 last1.
//     With UNPACK_MSB_FIRST_EN, test 1 yields A5 (lane1) then 5A (lane0, last).

Source files
------------

// File: rtl/byte_lane_unpacker_pkg.sv
// Shared types and lane helpers for the byte-enabled word unpacker.
package byte_lane_pkg;

    localparam int LANES      = 2;
    localparam int LANE_W     = 8;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;
    typedef logic [LANES-1:0]      lane_mask_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // The last enabled lane visited by the scan wins, so the scan direction sets the priority.
    function automatic lane_idx_t first_lane(input lane_mask_t mask, input logic msb_first);
        lane_idx_t idx;
        idx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (msb_first) begin
                idx = mask[i] ? lane_idx_t'(i) : idx;
            end else begin
                idx = mask[LANES-1-i] ? lane_idx_t'(LANES-1-i) : idx;
            end
        end
        return idx;
    endfunction

    function automatic logic onehot_cnt_le1(input lane_mask_t mask);
        return (mask & (mask - lane_mask_t'(1))) == lane_mask_t'(0);
    endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Combinational priority encoder picking the next lane to emit from a lane mask.
module lane_prio_enc #(
    parameter int LANES     = byte_lane_pkg::LANES,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [LANES-1:0]          mask,
    output byte_lane_pkg::lane_idx_t  idx,
    output logic                      any
);
    import byte_lane_pkg::*;

    assign idx = first_lane(mask, MSB_FIRST);
    assign any = |mask;

endmodule

// File: rtl/byte_lane_unpacker.sv
// Serialises the enabled byte lanes of each accepted word into a valid/ready byte stream.
// Define UNPACK_MSB_FIRST_EN to emit lanes highest-index first instead of lowest-index first.
module byte_lane_unpacker #(
    parameter int LANES  = byte_lane_pkg::LANES,
    parameter int LANE_W = byte_lane_pkg::LANE_W,
    localparam int W     = LANES * LANE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          byteena,
    input  logic [W-1:0]              d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W-1:0]         q,
    output byte_lane_pkg::lane_idx_t  q_lane,
    output logic                      q_last
);
    import byte_lane_pkg::*;

`ifdef UNPACK_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam logic [LANES-1:0] LANE0_BIT = LANES'(1);

    state_t              state_q, state_d;
    logic [W-1:0]        word_q, word_d;
    logic [LANES-1:0]    mask_q, mask_d;
    logic                out_valid_q, out_valid_d;
    logic [LANE_W-1:0]   q_q, q_d;
    lane_idx_t           q_lane_q, q_lane_d;
    logic                q_last_q, q_last_d;

    logic                in_ready_s;
    logic                accept_s;
    logic [LANES-1:0]    mask_rem_s;
    logic [LANES-1:0]    enc_mask_s;
    lane_idx_t           enc_idx_s;
    logic                enc_any_s;
    logic [W-1:0]        src_word_s;
    logic [LANE_W-1:0]   lane_data_s;

    // Upstream is only offered a slot when idle or while the final lane of the held word retires.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else if (state_q == IDLE) begin
            in_ready_s = 1'b1;
        end else if (out_ready && q_last_q) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s    = in_valid && in_ready_s;
    assign mask_rem_s  = mask_q & ~(LANE0_BIT << q_lane_q);
    assign enc_mask_s  = accept_s ? byteena : mask_rem_s;
    assign src_word_s  = accept_s ? d : word_q;
    assign lane_data_s = src_word_s[enc_idx_s*LANE_W +: LANE_W];

    lane_prio_enc #(
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .mask (enc_mask_s),
        .idx  (enc_idx_s),
        .any  (enc_any_s)
    );

    // Next-state logic: load a fresh word, advance to the next lane, or drain back to idle.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        q_lane_d    = q_lane_q;
        q_last_d    = q_last_q;
        case (state_q)
            IDLE: begin
                if (accept_s && enc_any_s) begin
                    state_d     = SEND;
                    word_d      = d;
                    mask_d      = byteena;
                    out_valid_d = 1'b1;
                    q_d         = lane_data_s;
                    q_lane_d    = enc_idx_s;
                    q_last_d    = onehot_cnt_le1(byteena);
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!out_ready) begin
                    state_d = SEND;
                end else if (!q_last_q) begin
                    mask_d   = mask_rem_s;
                    q_d      = lane_data_s;
                    q_lane_d = enc_idx_s;
                    q_last_d = onehot_cnt_le1(mask_rem_s);
                end else if (accept_s && enc_any_s) begin
                    word_d      = d;
                    mask_d      = byteena;
                    out_valid_d = 1'b1;
                    q_d         = lane_data_s;
                    q_lane_d    = enc_idx_s;
                    q_last_d    = onehot_cnt_le1(byteena);
                end else begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    word_d      = '0;
                    mask_d      = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            q_lane_q    <= '0;
            q_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            q_lane_q    <= q_lane_d;
            q_last_q    <= q_last_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign q_lane    = q_lane_q;
    assign q_last    = q_last_q;

endmodule

// File: tb/tb_byte_lane_unpacker.sv
// Self-checking bench for byte_lane_unpacker: vector table, corner sequences and a random scoreboard run.
module tb_byte_lane_unpacker;
    import byte_lane_pkg::*;

`ifdef UNPACK_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    typedef struct { logic [7:0] data; logic lane; logic last; } beat_t;
    typedef struct { logic [1:0] be; logic [15:0] d; } word_t;
    typedef struct { logic [1:0] be; logic [15:0] d; int n; beat_t b0; beat_t b1; } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  byteena;
    logic [15:0] d;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    lane_idx_t   q_lane;
    logic        q_last;

    byte_lane_unpacker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .byteena   (byteena),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .q_lane    (q_lane),
        .q_last    (q_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t obs[$];
    word_t src[$];
    bit    iv_en;
    bit    out_rdy_v;
    int    checks;
    int    errors;
    int    acc_cnt;
    vec_t  vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every enabled lane becomes one beat, in emission order, last flag on the final one.
    task automatic model_push(input logic [1:0] be, input logic [15:0] wd);
        int cnt;
        int seen;
        int i;
        cnt  = $countones(be);
        seen = 0;
        for (int j = 0; j < 2; j++) begin
            i = MSB ? 1 - j : j;
            if (be[i]) begin
                seen++;
                exp_q.push_back('{data: wd[i*8 +: 8], lane: 1'(i), last: (seen == cnt)});
            end
        end
    endtask

    task automatic tick();
        bit    exp_rdy;
        bit    acc;
        bit    cons;
        beat_t e;
        if (src.size() > 0 && iv_en) begin
            in_valid = 1'b1;
            byteena  = src[0].be;
            d        = src[0].d;
        end else begin
            in_valid = 1'b0;
            byteena  = 2'b00;
            d        = 16'h0000;
        end
        out_ready = out_rdy_v;
        #2;
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_rdy_v);
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_q.size() > 0 && out_valid) begin
            e = exp_q[0];
            chk("q", 32'(q), 32'(e.data));
            chk("q_lane", 32'(q_lane), 32'(e.lane));
            chk("q_last", 32'(q_last), 32'(e.last));
        end
        if (out_valid && out_ready) obs.push_back('{data: q, lane: q_lane[0], last: q_last});
        acc  = in_valid && exp_rdy;
        cons = (exp_q.size() > 0) && out_rdy_v;
        @(posedge clk);
        if (cons) void'(exp_q.pop_front());
        if (acc) begin
            model_push(src[0].be, src[0].d);
            void'(src.pop_front());
            acc_cnt++;
        end
        #1;
    endtask

    task automatic run_until_idle(input int bound, input string name);
        int n;
        n = 0;
        while ((src.size() > 0 || exp_q.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(src.size() > 0 || exp_q.size() > 0), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        byteena   = 2'b00;
        d         = 16'h0000;
        #2;
        chk("rst_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_q_lane", 32'(q_lane), 32'd0);
        chk("rst_q_last", 32'(q_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        src.delete();
    endtask

    task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
        chk({name, "_data"}, 32'(act.data), 32'(exp.data));
        chk({name, "_lane"}, 32'(act.lane), 32'(exp.lane));
        chk({name, "_last"}, 32'(act.last), 32'(exp.last));
    endtask

    initial begin
        logic [7:0] first_b;
        logic [7:0] second_b;
        checks    = 0;
        errors    = 0;
        acc_cnt   = 0;
        iv_en     = 1'b1;
        out_rdy_v = 1'b1;

`ifdef UNPACK_MSB_FIRST_EN
        vecs[0] = '{be: 2'b11, d: 16'hA55A, n: 2, b0: '{8'hA5, 1'b1, 1'b0}, b1: '{8'h5A, 1'b0, 1'b1}};
        vecs[4] = '{be: 2'b11, d: 16'h0F0E, n: 2, b0: '{8'h0F, 1'b1, 1'b0}, b1: '{8'h0E, 1'b0, 1'b1}};
`else
        vecs[0] = '{be: 2'b11, d: 16'hA55A, n: 2, b0: '{8'h5A, 1'b0, 1'b0}, b1: '{8'hA5, 1'b1, 1'b1}};
        vecs[4] = '{be: 2'b11, d: 16'h0F0E, n: 2, b0: '{8'h0E, 1'b0, 1'b0}, b1: '{8'h0F, 1'b1, 1'b1}};
`endif
        vecs[1] = '{be: 2'b10, d: 16'h1234, n: 1, b0: '{8'h12, 1'b1, 1'b1}, b1: '{8'h00, 1'b0, 1'b0}};
        vecs[2] = '{be: 2'b01, d: 16'h1234, n: 1, b0: '{8'h34, 1'b0, 1'b1}, b1: '{8'h00, 1'b0, 1'b0}};
        vecs[3] = '{be: 2'b00, d: 16'hABCD, n: 0, b0: '{8'h00, 1'b0, 1'b0}, b1: '{8'h00, 1'b0, 1'b0}};

        do_reset();

        // Table: one word at a time, consumer always ready.
        for (int v = 0; v < 5; v++) begin
            obs.delete();
            src.push_back('{be: vecs[v].be, d: vecs[v].d});
            run_until_idle(20, "vec");
            chk("vec_beats", 32'(obs.size()), 32'(vecs[v].n));
            if (obs.size() > 0 && vecs[v].n > 0) chk_beat("vec_b0", obs[0], vecs[v].b0);
            if (obs.size() > 1 && vecs[v].n > 1) chk_beat("vec_b1", obs[1], vecs[v].b1);
        end

        // Empty words are swallowed one per cycle.
        obs.delete();
        acc_cnt = 0;
        for (int k = 0; k < 3; k++) src.push_back('{be: 2'b00, d: 16'h5555});
        run_until_idle(10, "empty");
        chk("empty_accepts", 32'(acc_cnt), 32'd3);
        chk("empty_beats", 32'(obs.size()), 32'd0);

        // Back-to-back words: four beats in four cycles after the first accept.
        obs.delete();
        src.push_back('{be: 2'b11, d: 16'h1111});
        src.push_back('{be: 2'b11, d: 16'h2222});
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("b2b_beats", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            chk("b2b_0", 32'(obs[0].data), 32'h11);
            chk("b2b_1", 32'(obs[1].data), 32'h11);
            chk("b2b_2", 32'(obs[2].data), 32'h22);
            chk("b2b_3", 32'(obs[3].data), 32'h22);
        end
        run_until_idle(10, "b2b");

        // Backpressure on the first beat.
        first_b  = MSB ? 8'hBE : 8'hEF;
        second_b = MSB ? 8'hEF : 8'hBE;
        obs.delete();
        out_rdy_v = 1'b0;
        src.push_back('{be: 2'b11, d: 16'hBEEF});
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_q", 32'(q), 32'(first_b));
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_rdy_v = 1'b1;
        run_until_idle(10, "stall");
        chk("stall_beats", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) begin
            chk("stall_b0", 32'(obs[0].data), 32'(first_b));
            chk("stall_b1", 32'(obs[1].data), 32'(second_b));
        end

        // Reset mid-word drops the remaining lane.
        obs.delete();
        src.push_back('{be: 2'b11, d: 16'hCAFE});
        tick();
        tick();
        chk("midrst_beats", 32'(obs.size()), 32'd1);
        do_reset();
        obs.delete();
        src.push_back('{be: 2'b01, d: 16'h0077});
        run_until_idle(10, "postrst");
        chk("postrst_beats", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) chk_beat("postrst_b0", obs[0], '{8'h77, 1'b0, 1'b1});

        // Random traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            if (src.size() < 2 && $urandom_range(2, 0) == 0)
                src.push_back('{be: 2'($urandom_range(3, 0)), d: 16'($urandom)});
            iv_en     = ($urandom_range(3, 0) != 0);
            out_rdy_v = ($urandom_range(2, 0) != 0);
            tick();
        end
        iv_en     = 1'b1;
        out_rdy_v = 1'b1;
        run_until_idle(50, "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
